dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bus between a data-memory initiator and dmem_responder.
interface dmem_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_w;
  logic        i_req_byte;
  logic        i_req_hwrd;
  logic        i_req_rdu;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_req_addr, i_req_w, i_req_byte, i_req_hwrd, i_req_rdu,
           i_req_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_w, i_req_byte, i_req_hwrd, i_req_rdu,
           i_req_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory answering byte/halfword/word loads and stores
// through a valid/ready request and response handshake with fixed latency.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  dmem_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        accept, go_resp;

  logic [31:0] addr_p0, wdata_p0;
  logic        w_p0, byte_p0, hwrd_p0, rdu_p0;

  logic [31:0] acc_addr, acc_wdata;
  logic        acc_w, acc_byte, acc_hwrd, acc_rdu;
  logic        acc_err, in_range, misalign;
  logic [AW-1:0] acc_idx;
  logic [31:0] rd_word, wr_word, rsp_word;

  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic is_byte, input logic is_half,
                                              input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    if (is_byte)      load_extend = zext ? {24'd0, b} : {{24{b[7]}}, b};
    else if (is_half) load_extend = zext ? {16'd0, h} : {{16{h[15]}}, h};
    else              load_extend = word;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic is_byte, input logic is_half,
                                              input logic [31:0] wdata);
    store_merge = word;
    if (is_byte)      store_merge[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (is_half) store_merge[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else              store_merge = wdata;
  endfunction

  assign accept = (state == IDLE) && bus.i_req_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_nxt   = 3'd0;
        state_nxt = (LATENCY > 0) ? WAIT : RESP;
      end
      WAIT: if (cnt == LAST) state_nxt = RESP;
            else cnt_nxt = cnt + 3'd1;
      RESP: if (bus.i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign go_resp = (state != RESP) && (state_nxt == RESP) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stage p0: request capture at the accepting edge
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_p0  <= bus.i_req_addr;
      wdata_p0 <= bus.i_req_wdata;
      w_p0     <= bus.i_req_w;
      byte_p0  <= bus.i_req_byte;
      hwrd_p0  <= bus.i_req_hwrd;
      rdu_p0   <= bus.i_req_rdu;
    end
  end

  // With zero latency the access happens on the accepting edge, so it reads the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = bus.i_req_addr;
      acc_wdata = bus.i_req_wdata;
      acc_w     = bus.i_req_w;
      acc_byte  = bus.i_req_byte;
      acc_hwrd  = bus.i_req_hwrd;
      acc_rdu   = bus.i_req_rdu;
    end else begin
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
      acc_w     = w_p0;
      acc_byte  = byte_p0;
      acc_hwrd  = hwrd_p0;
      acc_rdu   = rdu_p0;
    end
  end

  assign in_range = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
  assign misalign = !acc_byte && (acc_hwrd ? acc_addr[0] : (acc_addr[1:0] != 2'b00));
  assign acc_err  = misalign || !in_range;
  assign acc_idx  = acc_addr[AW+1:2];
  assign rd_word  = in_range ? mem[acc_idx] : 32'd0;
  assign wr_word  = store_merge(rd_word, acc_addr[1:0], acc_byte, acc_hwrd, acc_wdata);
  assign rsp_word = (acc_err || acc_w) ? 32'd0
                  : load_extend(rd_word, acc_addr[1:0], acc_byte, acc_hwrd, acc_rdu);

  // Stage p1: memory update and response registers on the edge entering RESP
  always_ff @(posedge i_clk) begin
    if (go_resp && acc_w && !acc_err) mem[acc_idx] <= wr_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (go_resp) begin
      rdata_q <= rsp_word;
      err_q   <= acc_err;
    end
  end

  assign bus.o_req_ready = (state == IDLE);
  assign bus.o_rsp_valid = (state == RESP) && !i_rst;
  assign bus.o_rsp_rdata = i_rst ? 32'd0 : rdata_q;
  assign bus.o_rsp_err   = !i_rst && err_q;

endmodule
